// File: rtl/rggen_apb_pkg.sv
//------------------------------------------------------------------------------
// Module  : rggen_apb_pkg
// Brief   : Shared types and helpers for the APB register access front end.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rggen_apb_pkg;

    localparam int MAX_DATA_WIDTH   = 1024;
    localparam int MAX_STROBE_WIDTH = MAX_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } apb_state_e;

    function automatic int byte_offset_width(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Each strobe bit covers one byte lane; callers slice off the lanes they use.
    function automatic logic [MAX_DATA_WIDTH-1:0] expand_strobe(
        input logic [MAX_STROBE_WIDTH-1:0] strobe
    );
        logic [MAX_DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_STROBE_WIDTH; i++) begin
            mask[8*i +: 8] = {8{strobe[i]}};
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rggen_register_read_mux.sv
//------------------------------------------------------------------------------
// Module  : rggen_register_read_mux
// Brief   : Indexed selector returning one slot's read data, or zero on miss.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rggen_register_read_mux #(
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_COUNT = 4,
    parameter int INDEX_WIDTH    = 6
) (
    input  logic [INDEX_WIDTH-1:0]               index,
    input  logic                                 hit,
    input  logic [REGISTER_COUNT*DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0]                data
);

    always_comb begin
        data = '0;
        for (int i = 0; i < REGISTER_COUNT; i++) begin
            if (hit && (index == INDEX_WIDTH'(i))) begin
                data = read_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rggen_apb_register_access.sv
//------------------------------------------------------------------------------
// Module  : rggen_apb_register_access
// Brief   : APB4 slave turning bus transfers into one-cycle register strobes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rggen_apb_register_access
    import rggen_apb_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTER_COUNT = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 psel,
    input  logic                                 penable,
    input  logic                                 pwrite,
    input  logic [ADDRESS_WIDTH-1:0]             paddr,
    input  logic [DATA_WIDTH-1:0]                pwdata,
    input  logic [DATA_WIDTH/8-1:0]              pstrb,
    output logic                                 pready,
    output logic [DATA_WIDTH-1:0]                prdata,
    output logic                                 pslverr,
    output logic [REGISTER_COUNT-1:0]            o_write_access,
    output logic [REGISTER_COUNT-1:0]            o_read_access,
    output logic [DATA_WIDTH-1:0]                o_write_data,
    output logic [DATA_WIDTH-1:0]                o_write_mask,
    input  logic [REGISTER_COUNT*DATA_WIDTH-1:0] i_read_data
);

    localparam int OFFSET_WIDTH = byte_offset_width(DATA_WIDTH);
    localparam int INDEX_WIDTH  = ADDRESS_WIDTH - OFFSET_WIDTH;

    apb_state_e                 r_state;
    logic [INDEX_WIDTH-1:0]     r_index;
    logic                       r_hit;
    logic                       r_write;
    logic                       r_pready;
    logic                       r_pslverr;
    logic [DATA_WIDTH-1:0]      r_prdata;
    logic [DATA_WIDTH-1:0]      r_write_data;
    logic [DATA_WIDTH-1:0]      r_write_mask;

    logic [INDEX_WIDTH-1:0]     w_index;
    logic                       w_hit;
    logic [MAX_DATA_WIDTH-1:0]  w_mask_full;
    logic [DATA_WIDTH-1:0]      w_mask;
    logic [DATA_WIDTH-1:0]      w_read_data;
    logic                       w_access_cycle;

    assign w_index     = paddr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
    assign w_hit       = (32'(w_index) < 32'(REGISTER_COUNT));
    assign w_mask_full = expand_strobe(MAX_STROBE_WIDTH'(pstrb));
    assign w_mask      = w_mask_full[DATA_WIDTH-1:0];

    // Byte-offset bits and unused strobe lanes are deliberately ignored.
    generate
        if (OFFSET_WIDTH > 0) begin : g_offset
            logic w_unused_offset;
            assign w_unused_offset = ^paddr[OFFSET_WIDTH-1:0];
        end
        if (DATA_WIDTH < MAX_DATA_WIDTH) begin : g_mask_hi
            logic w_unused_mask_hi;
            assign w_unused_mask_hi = |w_mask_full[MAX_DATA_WIDTH-1:DATA_WIDTH];
        end
    endgenerate

    rggen_register_read_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REGISTER_COUNT (REGISTER_COUNT),
        .INDEX_WIDTH    (INDEX_WIDTH)
    ) u_read_mux (
        .index     (r_index),
        .hit       (r_hit & ~r_write),
        .read_data (i_read_data),
        .data      (w_read_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_index      <= '0;
            r_hit        <= 1'b0;
            r_write      <= 1'b0;
            r_pready     <= 1'b0;
            r_pslverr    <= 1'b0;
            r_prdata     <= '0;
            r_write_data <= '0;
            r_write_mask <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (psel && !penable) begin
                        r_index      <= w_index;
                        r_hit        <= w_hit;
                        r_write      <= pwrite;
                        r_write_data <= pwdata;
                        r_write_mask <= w_mask;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        r_state <= IDLE;
                    end else if (penable) begin
                        r_prdata  <= w_read_data;
                        r_pslverr <= ~r_hit;
                        r_pready  <= 1'b1;
                        r_state   <= RESPOND;
                    end
                end
                RESPOND: begin
                    r_pready <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_pready <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    // Strobes come straight from registered decode so they last exactly the access cycle.
    assign w_access_cycle = (r_state == ACCESS) && psel && penable && r_hit;

    always_comb begin
        o_write_access = '0;
        o_read_access  = '0;
        for (int i = 0; i < REGISTER_COUNT; i++) begin
            if (w_access_cycle && (r_index == INDEX_WIDTH'(i))) begin
                o_write_access[i] = r_write;
                o_read_access[i]  = ~r_write;
            end
        end
    end

    assign pready       = r_pready;
    assign pslverr      = r_pslverr;
    assign prdata       = r_prdata;
    assign o_write_data = r_write_data;
    assign o_write_mask = r_write_mask;

endmodule

`default_nettype wire

// File: tb/tb_rggen_apb_register_access.sv
//------------------------------------------------------------------------------
// Module  : tb_rggen_apb_register_access
// Brief   : Directed and random APB transfers checked against a slot model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rggen_apb_register_access;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         psel = 1'b0;
    logic         penable = 1'b0;
    logic         pwrite = 1'b0;
    logic [7:0]   paddr = '0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic         pready;
    logic [31:0]  prdata;
    logic         pslverr;
    logic [3:0]   o_write_access;
    logic [3:0]   o_read_access;
    logic [31:0]  o_write_data;
    logic [31:0]  o_write_mask;
    logic [127:0] i_read_data;

    int errors = 0;
    int checks = 0;

    // Environment: slots 0..2 behave as rw fields, slot 3 is a read-only value.
    logic [31:0] slot_q [3] = '{default: 32'h0};
    logic [31:0] ro3 = 32'hA5A5_0001;

    // Reference model of the register contents.
    logic [31:0] model [3] = '{default: 32'h0};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (o_write_access[i]) begin
                slot_q[i] <= (slot_q[i] & ~o_write_mask) | (o_write_data & o_write_mask);
            end
        end
    end

    assign i_read_data = {ro3, slot_q[2], slot_q[1], slot_q[0]};

    rggen_apb_register_access #(
        .ADDRESS_WIDTH  (8),
        .DATA_WIDTH     (32),
        .REGISTER_COUNT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .psel           (psel),
        .penable        (penable),
        .pwrite         (pwrite),
        .paddr          (paddr),
        .pwdata         (pwdata),
        .pstrb          (pstrb),
        .pready         (pready),
        .prdata         (prdata),
        .pslverr        (pslverr),
        .o_write_access (o_write_access),
        .o_read_access  (o_read_access),
        .o_write_data   (o_write_data),
        .o_write_mask   (o_write_mask),
        .i_read_data    (i_read_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) m = m | (32'hFF << (8 * b));
        end
        return m;
    endfunction

    // Starts with the setup phase in the current cycle; ends one cycle after pready.
    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [31:0] rdata);
        int          idx;
        bit          hit;
        logic [3:0]  exp_strobe;
        logic [31:0] exp_mask;
        logic [31:0] exp_rd;
        idx        = int'(addr) / 4;
        hit        = (idx < 4);
        exp_strobe = hit ? (4'b0001 << idx) : 4'b0000;
        exp_mask   = byte_mask(strb);
        exp_rd     = 32'h0;
        if (!wr && hit) exp_rd = (idx == 3) ? ro3 : model[idx];

        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        #1;
        check("setup_strobes", {24'h0, o_write_access, o_read_access}, 32'h0);
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        check("access_wr_strobe", {28'h0, o_write_access}, wr ? {28'h0, exp_strobe} : 32'h0);
        check("access_rd_strobe", {28'h0, o_read_access}, wr ? 32'h0 : {28'h0, exp_strobe});
        check("access_wdata", o_write_data, data);
        check("access_wmask", o_write_mask, exp_mask);
        check("access_pready", {31'h0, pready}, 32'h0);
        @(posedge clk); #1;
        check("resp_pready", {31'h0, pready}, 32'h1);
        check("resp_pslverr", {31'h0, pslverr}, {31'h0, !hit});
        check("resp_prdata", prdata, exp_rd);
        check("resp_strobes", {24'h0, o_write_access, o_read_access}, 32'h0);
        rdata = prdata;
        if (wr && hit && idx < 3) model[idx] = (model[idx] & ~exp_mask) | (data & exp_mask);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        #1;
        check("done_pready", {31'h0, pready}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] wv;
        bit          wr;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", {31'h0, pready}, 32'h0);
        check("rst_pslverr", {31'h0, pslverr}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_strobes", {24'h0, o_write_access, o_read_access}, 32'h0);
        check("rst_wdata", o_write_data, 32'h0);
        check("rst_wmask", o_write_mask, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset lands in the middle of a write to slot 1.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04;
        pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        check("midrst_inflight", {28'h0, o_write_access}, 32'h2);
        rst = 1'b1;
        #1;
        check("midrst_strobe", {24'h0, o_write_access, o_read_access}, 32'h0);
        check("midrst_pready", {31'h0, pready}, 32'h0);
        check("midrst_wdata", o_write_data, 32'h0);
        check("midrst_wmask", o_write_mask, 32'h0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 8'h04, 32'h0, 4'h0, rd);
        check("midrst_slot1", rd, 32'h0);

        // Directed transfers.
        xfer(1'b1, 8'h04, 32'hDEAD_BEEF, 4'b1111, rd);
        check("wr04_prdata", rd, 32'h0);
        xfer(1'b1, 8'h08, 32'h1234_5678, 4'b0101, rd);
        xfer(1'b0, 8'h08, 32'h0, 4'h0, rd);
        check("rd08_value", rd, 32'h0034_0078);
        xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd);
        check("rd0c_value", rd, 32'hA5A5_0001);
        xfer(1'b0, 8'h10, 32'h0, 4'h0, rd);
        xfer(1'b1, 8'h10, 32'hFFFF_FFFF, 4'hF, rd);
        xfer(1'b1, 8'h04, 32'h5555_AAAA, 4'h0, rd);
        xfer(1'b0, 8'h04, 32'h0, 4'h0, rd);
        check("zero_strobe_keep", rd, 32'hDEAD_BEEF);

        // Back-to-back: read setup presented right after the write's response cycle.
        xfer(1'b1, 8'h00, 32'h0BAD_C0DE, 4'hF, rd);
        xfer(1'b0, 8'h00, 32'h0, 4'h0, rd);
        check("b2b_readback", rd, 32'h0BAD_C0DE);

        // Random traffic, including misses, byte offsets and idle gaps.
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1));
            wv = $urandom;
            xfer(wr, 8'($urandom_range(0, 19)), wv, 4'($urandom_range(0, 15)), rd);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
